edac_word_reader: RTL and testbench
===================================

EDAC_WORD_READER -- requirements
Module: edac_word_reader

Interface
REQ-001 SHALL have parameter ERROR_CODE, default 32'hFFFFFFFF: the DOUT value on any failed read.
REQ-002 SHALL have parameter CRC, default 8'h97: the CRC-8 polynomial, x^8 term implied.
REQ-003 SHALL have parameter TIMEOUT, default 15: the maximum number of enabled cycles to wait for mem_ack per codeword.
REQ-004 SHALL use one clock and an asynchronous active-high reset.
REQ-005 CLK  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 en  in  1  clock enable; while low, all state and outputs hold.
REQ-008 start  in  1  request a 32-bit word read; sampled only in IDLE.
REQ-009 base_addr  in  8  codeword address of nibble 0, sampled together with start.
REQ-010 mem_rd  out  1  memory read request.
REQ-011 mem_addr  out  8  codeword address, equal to base_addr+idx modulo 256.
REQ-012 mem_ack  in  1  memory has mem_rdata valid this cycle.
REQ-013 mem_rdata  in  16  codeword.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse; DOUT, valid, err_idx and timeout are updated in the same cycle.
REQ-016 DOUT  out  32  assembled word, or ERROR_CODE on failure.
REQ-017 valid  out  1  the last read passed every check.
REQ-018 err_idx  out  3  index of the first failing codeword.
REQ-019 timeout  out  1  the last read was aborted on ack timeout.

Function
REQ-020 Codeword format SHALL be {4'b0000, crc[7:0], d[3:0]}.
- crc is the remainder of d(x)*x^8 mod (x^8+CRC).
- MSB-first, init 0x00, no reflection, no final XOR.
- Examples: d=1 gives 16'h0971; d=2 gives 16'h0B92; d=0 gives 16'h0000.
REQ-021 A codeword SHALL fail the check if bits [15:12] are not zero or the stored crc differs from the recomputed crc.
REQ-022 The state machine SHALL have states IDLE, FETCH and DONE.
REQ-023 IDLE -> FETCH on en&start:
- latch base_addr;
- idx=0, err=0, first-fail index=0;
- clear the wait counter.
REQ-024 In FETCH, mem_rd SHALL be held high and mem_addr held stable until mem_ack is sampled high.
REQ-025 On mem_ack in FETCH, the block SHALL:
- write data nibble d into assembly bits [4*idx+3:4*idx];
- run the check, and on the first failure set err and record idx;
- clear the wait counter;
- if idx=7, go to DONE with mem_rd=0; otherwise idx++ and keep mem_rd high with the next address on the following cycle.
REQ-026 The wait counter SHALL increment each enabled FETCH cycle without ack; when it reaches TIMEOUT, the block SHALL set the timeout flag, record the current idx, and go to DONE with mem_rd=0.
REQ-027 DONE lasts one cycle and then returns to IDLE; in it the block SHALL:
- pulse done=1;
- set DOUT to ERROR_CODE if err or timeout, otherwise to the assembled word;
- set valid to !(err|timeout);
- update err_idx and timeout.
REQ-028 With zero-wait ack, done SHALL assert 9 enabled cycles after the cycle in which start is sampled.
REQ-029 start SHALL be ignored while busy; mem_ack SHALL be ignored outside FETCH.
REQ-030 mem_addr SHALL wrap modulo 256, e.g. base 8'hFE reads FE, FF, 00 ... 05.
REQ-031 DOUT, valid, err_idx and timeout SHALL hold their values until the next DONE.
REQ-032 The error capture SHALL record only the first failure; the remaining codewords are still fetched.

Reset
REQ-033 On reset, the block SHALL return asynchronously to IDLE with every output zero: DOUT=0, valid=0, done=0, busy=0, mem_rd=0, mem_addr=0, err_idx=0, timeout=0.
REQ-034 A reset during FETCH SHALL abort the read with no done pulse; the next start SHALL begin from idx 0.

Verification
REQ-035 Good word: base 8'h10, zero-wait acks, codeword at 8'h10 = 16'h0971, all others 16'h0000 -> done at cycle 9, DOUT=32'h00000001, valid=1, timeout=0.
REQ-036 Nibble ordering: idx0..7 codewords carry d=1,2,0,0,0,0,0,1 -> DOUT=32'h10000021, valid=1.
REQ-037 CRC error: codeword idx3 = 16'h0001, idx5 = 16'h8000 -> all 8 fetched, DOUT=32'hFFFFFFFF, valid=0, err_idx=3.
REQ-038 Timeout: acks given for idx0..1, then ack withheld -> 15 cycles later done=1, timeout=1, err_idx=2, DOUT=32'hFFFFFFFF, mem_rd=0.
REQ-039 en/back-pressure: random ack delays below 15 cycles plus en toggling -> same DOUT as the zero-wait run, mem_addr stable while waiting, start pulses during busy ignored.
REQ-040 Reset mid-read: reset asserted at idx4 -> all outputs zero immediately; a fresh start with base 8'hFE reads addresses FE..05 and completes correctly.

Source files
------------

// File: rtl/edac_word_reader_if.sv
// Codeword memory port of the EDAC word reader: request/address out, ack/data back.
interface edac_word_reader_if;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (output mem_rd, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_rd, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/edac_word_reader.sv
// Reads eight CRC-8 protected nibble codewords and assembles them into one 32-bit word,
// reporting the first bad codeword or an ack timeout.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | requesting codeword idx, waiting for mem_ack
// DONE  | one-cycle result strobe, outputs already updated
module edac_word_reader #(
  parameter logic [31:0] ERROR_CODE = 32'hFFFFFFFF,
  parameter logic [7:0]  CRC        = 8'h97,
  parameter int          TIMEOUT    = 15
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               en,
  input  logic               start,
  input  logic [7:0]         base_addr,
  edac_word_reader_if.master mem,
  output logic               busy,
  output logic               done,
  output logic [31:0]        DOUT,
  output logic               valid,
  output logic [2:0]         err_idx,
  output logic               timeout
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  localparam logic [15:0] WAIT_LD = 16'(TIMEOUT);

  state_t      state;
  logic [7:0]  base_q;
  logic [2:0]  idx;
  logic        err;
  logic [2:0]  fail_idx;
  logic [15:0] wait_cnt;
  logic [31:0] word;

  logic        cw_fail;
  logic        err_nxt;
  logic [2:0]  fail_nxt;
  logic [31:0] word_nxt;

  function automatic logic [7:0] crc8(input logic [3:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 3; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? CRC : 8'h00);
    end
    return c;
  endfunction

  always_comb begin
    cw_fail  = (mem.mem_rdata[15:12] != 4'h0) ||
               (mem.mem_rdata[11:4] != crc8(mem.mem_rdata[3:0]));
    err_nxt  = err | cw_fail;
    fail_nxt = (cw_fail && !err) ? idx : fail_idx;
    word_nxt = word;
    word_nxt[{idx, 2'b00} +: 4] = mem.mem_rdata[3:0];
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      base_q       <= 8'h00;
      idx          <= 3'd0;
      err          <= 1'b0;
      fail_idx     <= 3'd0;
      wait_cnt     <= 16'd0;
      word         <= 32'h0;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
      DOUT         <= 32'h0;
      valid        <= 1'b0;
      err_idx      <= 3'd0;
      timeout      <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= FETCH;
            base_q       <= base_addr;
            idx          <= 3'd0;
            err          <= 1'b0;
            fail_idx     <= 3'd0;
            wait_cnt     <= WAIT_LD;
            word         <= 32'h0;
            mem.mem_rd   <= 1'b1;
            mem.mem_addr <= base_addr;
            busy         <= 1'b1;
          end
        end
        FETCH: begin
          if (mem.mem_ack) begin
            word     <= word_nxt;
            err      <= err_nxt;
            fail_idx <= fail_nxt;
            wait_cnt <= WAIT_LD;
            if (idx == 3'd7) begin
              state      <= DONE;
              mem.mem_rd <= 1'b0;
              done       <= 1'b1;
              DOUT       <= err_nxt ? ERROR_CODE : word_nxt;
              valid      <= !err_nxt;
              err_idx    <= fail_nxt;
              timeout    <= 1'b0;
            end else begin
              idx          <= idx + 3'd1;
              mem.mem_addr <= base_q + {5'b00000, idx} + 8'd1;
            end
          end else if (wait_cnt == 16'd1) begin
            // Down-counter terminal count: TIMEOUT enabled cycles without an ack.
            state      <= DONE;
            mem.mem_rd <= 1'b0;
            done       <= 1'b1;
            DOUT       <= ERROR_CODE;
            valid      <= 1'b0;
            err_idx    <= idx;
            timeout    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edac_word_reader.sv
// Directed bench for edac_word_reader: table of codeword images plus timeout,
// back-pressure and mid-read reset sequences.
module tb_edac_word_reader;

  logic        CLK;
  logic        reset;
  logic        en;
  logic        start;
  logic [7:0]  base_addr;
  logic        busy;
  logic        done;
  logic [31:0] DOUT;
  logic        valid;
  logic [2:0]  err_idx;
  logic        timeout;

  edac_word_reader_if mif ();

  edac_word_reader dut (
    .CLK       (CLK),
    .reset     (reset),
    .en        (en),
    .start     (start),
    .base_addr (base_addr),
    .mem       (mif.master),
    .busy      (busy),
    .done      (done),
    .DOUT      (DOUT),
    .valid     (valid),
    .err_idx   (err_idx),
    .timeout   (timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [7:0]        base;
    logic [7:0][15:0]  cw;
    logic [31:0]       dout;
    logic              valid;
    logic [2:0]        eidx;
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs [NVEC];

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] mem_img [256];
  logic [7:0]  addr_q [$];
  int          acc_cnt;
  int          ack_limit = 99;
  logic        rand_mode = 1'b0;
  logic        pending = 1'b0;
  logic [7:0]  req_addr;
  int          wait_left;
  logic        addr_moved;
  logic        last_en;

  // Reference CRC by long division of d*x^8 by {1,CRC}.
  function automatic logic [7:0] ref_crc(input logic [3:0] d);
    logic [11:0] v;
    logic [8:0]  g;
    g = {1'b1, 8'h97};
    v = {d, 8'h00};
    for (int b = 11; b >= 8; b--) begin
      if (v[b]) v = v ^ (12'(g) << (b - 8));
    end
    return v[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: observe the previous edge, then drive memory response and (optionally) random en/start.
  task automatic step();
    logic acc;
    @(negedge CLK);
    acc     = mif.mem_ack && en;
    last_en = en;
    if (acc) begin
      pending = 1'b0;
      acc_cnt++;
      addr_q.push_back(req_addr);
    end
    mif.mem_ack = 1'b0;
    if (rand_mode) begin
      en = ($urandom_range(0, 3) != 0);
      if (busy) begin
        start     = $urandom_range(0, 1) == 1;
        base_addr = 8'($urandom_range(0, 255));
      end
    end
    if (mif.mem_rd && acc_cnt < ack_limit) begin
      if (!pending) begin
        pending   = 1'b1;
        req_addr  = mif.mem_addr;
        wait_left = rand_mode ? $urandom_range(0, 8) : 0;
      end else if (mif.mem_addr != req_addr) begin
        addr_moved = 1'b1;
      end
      if (wait_left == 0) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = mem_img[mif.mem_addr];
      end else begin
        wait_left--;
      end
    end
  endtask

  task automatic run_read(input logic [7:0] b, input int budget, output int lat, output logic got);
    addr_q.delete();
    acc_cnt    = 0;
    addr_moved = 1'b0;
    pending    = 1'b0;
    got        = 1'b0;
    en         = 1'b1;
    start      = 1'b1;
    base_addr  = b;
    step();
    start = 1'b0;
    lat   = 1;
    for (int n = 0; n < budget; n++) begin
      step();
      if (last_en) lat++;
      if (done) begin
        got   = 1'b1;
        start = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_vec(input int v);
    int   lat;
    logic got;
    for (int a = 0; a < 256; a++) mem_img[a] = 16'h0000;
    for (int i = 0; i < 8; i++) mem_img[8'(vecs[v].base + 8'(i))] = vecs[v].cw[i];
    run_read(vecs[v].base, 400, lat, got);
    chk($sformatf("v%0d done seen", v), got, 1);
    if (!rand_mode) chk($sformatf("v%0d latency", v), lat, 9);
    chk($sformatf("v%0d DOUT", v), DOUT, vecs[v].dout);
    chk($sformatf("v%0d valid", v), valid, vecs[v].valid);
    chk($sformatf("v%0d err_idx", v), err_idx, vecs[v].eidx);
    chk($sformatf("v%0d timeout", v), timeout, 0);
    chk($sformatf("v%0d mem_rd", v), mif.mem_rd, 0);
    chk($sformatf("v%0d addr stable", v), addr_moved, 0);
    chk($sformatf("v%0d fetch count", v), addr_q.size(), 8);
    if (addr_q.size() == 8)
      for (int i = 0; i < 8; i++)
        chk($sformatf("v%0d addr%0d", v, i), addr_q[i], 8'(vecs[v].base + 8'(i)));
    if (!rand_mode) begin
      en = 1'b1;
      step();
      chk($sformatf("v%0d done pulse width", v), done, 0);
      chk($sformatf("v%0d busy after", v), busy, 0);
    end
  endtask

  initial begin
    int   lat;
    logic got;
    logic [31:0] w;

    for (int v = 0; v < NVEC; v++) begin
      vecs[v].cw    = '0;
      vecs[v].valid = 1'b1;
      vecs[v].eidx  = 3'd0;
    end
    vecs[0].base = 8'h10; vecs[0].cw[0] = 16'h0971; vecs[0].dout = 32'h00000001;
    vecs[1].base = 8'h20; vecs[1].cw[0] = 16'h0971; vecs[1].cw[1] = 16'h0B92;
    vecs[1].cw[7] = 16'h0971; vecs[1].dout = 32'h10000021;
    vecs[2].base = 8'h30; vecs[2].cw[3] = 16'h0001; vecs[2].cw[5] = 16'h8000;
    vecs[2].dout = 32'hFFFFFFFF; vecs[2].valid = 1'b0; vecs[2].eidx = 3'd3;
    vecs[3].base = 8'h80; vecs[3].cw[2] = 16'h1971; vecs[3].cw[6] = 16'h0B91;
    vecs[3].dout = 32'hFFFFFFFF; vecs[3].valid = 1'b0; vecs[3].eidx = 3'd2;
    vecs[4].base = 8'h90; vecs[4].cw[6] = 16'h0B91; vecs[4].cw[7] = 16'h0971;
    vecs[4].dout = 32'hFFFFFFFF; vecs[4].valid = 1'b0; vecs[4].eidx = 3'd6;
    w = 32'hDEADBEEF;
    vecs[5].base = 8'hFE; vecs[5].dout = w;
    for (int i = 0; i < 8; i++)
      vecs[5].cw[i] = {4'h0, ref_crc(w[4*i +: 4]), w[4*i +: 4]};

    reset = 1'b1; en = 1'b0; start = 1'b0; base_addr = 8'h00;
    mif.mem_ack = 1'b0; mif.mem_rdata = 16'h0000;
    #12;
    chk("reset ctrl", {busy, done, mif.mem_rd, valid, timeout, err_idx, mif.mem_addr}, 0);
    chk("reset DOUT", DOUT, 0);
    @(negedge CLK);
    reset = 1'b0;

    for (int v = 0; v < NVEC; v++) do_vec(v);

    // Ack withheld from idx2 onward.
    for (int a = 0; a < 256; a++) mem_img[a] = 16'h0000;
    ack_limit = 2;
    run_read(8'h40, 100, lat, got);
    ack_limit = 99;
    chk("to done seen", got, 1);
    chk("to latency", lat, 18);
    chk("to timeout", timeout, 1);
    chk("to err_idx", err_idx, 2);
    chk("to DOUT", DOUT, 32'hFFFFFFFF);
    chk("to valid", valid, 0);
    chk("to mem_rd", mif.mem_rd, 0);
    chk("to fetch count", addr_q.size(), 2);
    en = 1'b1;
    step();
    chk("to done pulse width", done, 0);

    // Random ack delays, en toggling and start pulses while busy.
    rand_mode = 1'b1;
    do_vec(1);
    rand_mode = 1'b0;
    en = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("bp no restart", busy, 0);
    chk("bp DOUT held", DOUT, 32'h10000021);

    // Reset while fetching idx4.
    for (int a = 0; a < 256; a++) mem_img[a] = 16'h0000;
    addr_q.delete(); acc_cnt = 0; pending = 1'b0;
    en = 1'b1; start = 1'b1; base_addr = 8'h60;
    step();
    start = 1'b0;
    for (int n = 0; n < 50 && acc_cnt < 4; n++) step();
    chk("rst reached idx4", acc_cnt, 4);
    #2 reset = 1'b1;
    #1;
    chk("rst mid ctrl", {busy, done, mif.mem_rd, valid, timeout, err_idx, mif.mem_addr}, 0);
    chk("rst mid DOUT", DOUT, 0);
    @(negedge CLK);
    reset = 1'b0; pending = 1'b0; mif.mem_ack = 1'b0;
    step();
    chk("rst no done", done, 0);
    do_vec(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
